// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access sizes, FSM states
// and the alignment rule used by both the datapath and the handshake logic.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;  // 2'b11 is handled as a word too

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } stateT;

  // Halfwords need an even address, words (and size 11) need a 4-byte boundary.
  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addrLo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addrLo[0];
      default: bad = (addrLo != 2'b00);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering between the CPU's right-justified data and the 32-bit RAM
// word: store lane enables/replication and load extraction with extension.
module mem_align
  import dmem_pkg::*;
(
  input  logic [1:0]  wrSize,
  input  logic [1:0]  wrAddrLo,
  input  logic [31:0] wrData,
  output logic [3:0]  laneWe,
  output logic [31:0] laneData,
  input  logic [1:0]  rdSize,
  input  logic [1:0]  rdAddrLo,
  input  logic        rdUnsigned,
  input  logic [31:0] rdWord,
  output logic [31:0] loadData
);

  logic [31:0] rdShifted;

  // Store path: replicate the small operand across the word so the lane enable
  // alone decides which bytes land in RAM.
  always_comb begin
    laneWe   = 4'b1111;
    laneData = wrData;
    case (wrSize)
      SZ_BYTE: begin
        laneWe   = 4'b0001 << wrAddrLo;
        laneData = {4{wrData[7:0]}};
      end
      SZ_HALF: begin
        laneWe   = 4'b0011 << {wrAddrLo[1], 1'b0};
        laneData = {2{wrData[15:0]}};
      end
      default: begin
        laneWe   = 4'b1111;
        laneData = wrData;
      end
    endcase
  end

  // Load path: bring the addressed lane down to bit 0, then zero/sign extend.
  always_comb begin
    rdShifted = rdWord >> {rdAddrLo, 3'b000};
    loadData  = rdWord;
    case (rdSize)
      SZ_BYTE: loadData = rdUnsigned ? {24'h000000, rdShifted[7:0]}
                                     : {{24{rdShifted[7]}}, rdShifted[7:0]};
      SZ_HALF: loadData = rdUnsigned ? {16'h0000, rdShifted[15:0]}
                                     : {{16{rdShifted[15]}}, rdShifted[15:0]};
      default: loadData = rdWord;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-stage data RAM with a fixed number of wait states. Accepts one
// aligned access from IDLE, stalls the pipeline through WAIT, and completes in
// a single RESP cycle. Misaligned requests are rejected with an exception pulse.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memenM,
  input  logic        memwriteM,
  input  logic [1:0]  sizeM,
  input  logic        unsignedM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  output logic [31:0] readdataM,
  output logic        stallM,
  output logic        adelM,
  output logic        adesM
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  stateT       stateReg;
  logic [3:0]  cntReg;
  logic [31:0] addrReg, dataReg;
  logic [1:0]  sizeReg;
  logic        writeReg, unsignedReg;

  // Last completed load: raw RAM word plus what is needed to re-extract it,
  // so readdataM holds steady while later stores go through.
  logic [31:0] rdWordReg;
  logic [1:0]  rdSizeReg, rdAddrLoReg;
  logic        rdUnsignedReg;

  logic [31:0] ram [DEPTH_WORDS];

  logic          inIdle, misaligned, accept, enterResp;
  logic [31:0]   curAddr, curData;
  logic [1:0]    curSize;
  logic          curWrite, curUnsigned;
  logic [AW-1:0] curIdx;
  logic [3:0]    laneWe;
  logic [31:0]   laneData;
  logic          unusedAddrBits;

  // Request decode. With zero wait states the RAM is touched on the accept
  // edge itself, so the live inputs are used while in IDLE.
  always_comb begin
    inIdle      = (stateReg == IDLE);
    misaligned  = isMisaligned(sizeM, aluoutM[1:0]);
    accept      = inIdle && memenM && !misaligned;
    curAddr     = inIdle ? aluoutM    : addrReg;
    curData     = inIdle ? writedataM : dataReg;
    curSize     = inIdle ? sizeM      : sizeReg;
    curWrite    = inIdle ? memwriteM  : writeReg;
    curUnsigned = inIdle ? unsignedM  : unsignedReg;
    curIdx      = curAddr[AW+1:2];
    enterResp   = !rst && (((stateReg == WAIT) && (cntReg == 4'd0)) ||
                           (accept && (WAIT_CYCLES == 0)));
    stallM      = accept || (stateReg == WAIT);
    adelM       = inIdle && memenM && !memwriteM && misaligned;
    adesM       = inIdle && memenM &&  memwriteM && misaligned;
  end

  // Upper address bits alias onto the same words by design.
  assign unusedAddrBits = ^curAddr[31:AW+2];

  // Handshake FSM: latch the request on accept, count wait states, one RESP cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg <= IDLE;
      cntReg   <= 4'd0;
    end else begin
      case (stateReg)
        IDLE: begin
          if (accept) begin
            addrReg     <= aluoutM;
            dataReg     <= writedataM;
            sizeReg     <= sizeM;
            writeReg    <= memwriteM;
            unsignedReg <= unsignedM;
            cntReg      <= CNT_INIT;
            stateReg    <= (WAIT_CYCLES > 0) ? WAIT : RESP;
          end
        end
        WAIT: begin
          if (cntReg == 4'd0) stateReg <= RESP;
          else                cntReg   <= cntReg - 4'd1;
        end
        RESP:    stateReg <= IDLE;
        default: stateReg <= IDLE;
      endcase
    end
  end

  // Store commit on the edge entering RESP; a reset before then drops it.
  always_ff @(posedge clk) begin
    if (enterResp && curWrite) begin
      for (int b = 0; b < 4; b++) begin
        if (laneWe[b]) ram[curIdx][8*b +: 8] <= laneData[8*b +: 8];
      end
    end
  end

  // Registered RAM read for loads, captured on the edge entering RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdWordReg     <= 32'h0;
      rdSizeReg     <= SZ_WORD;
      rdAddrLoReg   <= 2'b00;
      rdUnsignedReg <= 1'b0;
    end else if (enterResp && !curWrite) begin
      rdWordReg     <= ram[curIdx];
      rdSizeReg     <= curSize;
      rdAddrLoReg   <= curAddr[1:0];
      rdUnsignedReg <= curUnsigned;
    end
  end

  mem_align uAlign (
    .wrSize     (curSize),
    .wrAddrLo   (curAddr[1:0]),
    .wrData     (curData),
    .laneWe     (laneWe),
    .laneData   (laneData),
    .rdSize     (rdSizeReg),
    .rdAddrLo   (rdAddrLoReg),
    .rdUnsigned (rdUnsignedReg),
    .rdWord     (rdWordReg),
    .loadData   (readdataM)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states and one
// with none. Drivers push the expected readdataM into a per-instance queue; a
// monitor pops and compares in every RESP cycle.
module tb_dmem_responder;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        memen2, memen0;
  logic        memwriteM, unsignedM;
  logic [1:0]  sizeM;
  logic [31:0] aluoutM, writedataM;
  logic [31:0] rd2, rd0;
  logic        stall2, stall0, adel2, adel0, ades2, ades0;

  int nChecks = 0;
  int nFails  = 0;

  logic [31:0] q2[$];
  logic [31:0] q0[$];
  logic        prevStall2 = 1'b0, prevStall0 = 1'b0;
  logic        prevRst2 = 1'b1, prevRst0 = 1'b1;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .memenM(memen2), .memwriteM(memwriteM), .sizeM(sizeM),
    .unsignedM(unsignedM), .aluoutM(aluoutM), .writedataM(writedataM),
    .readdataM(rd2), .stallM(stall2), .adelM(adel2), .adesM(ades2)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .memenM(memen0), .memwriteM(memwriteM), .sizeM(sizeM),
    .unsignedM(unsignedM), .aluoutM(aluoutM), .writedataM(writedataM),
    .readdataM(rd0), .stallM(stall0), .adelM(adel0), .adesM(ades0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  function automatic logic stallOf(input bit zw);
    return zw ? stall0 : stall2;
  endfunction

  // Response monitors: RESP is the first stall-free cycle after a stalled one,
  // unless a reset intervened.
  always @(negedge clk) begin
    if (!prevRst2 && prevStall2 && !stall2) begin
      if (q2.size() == 0) check("resp2 unexpected", rd2, 32'hxxxxxxxx);
      else check("resp2 readdataM", rd2, q2.pop_front());
    end
    prevStall2 = stall2;
    prevRst2   = rst;
  end

  always @(negedge clk) begin
    if (!prevRst0 && prevStall0 && !stall0) begin
      if (q0.size() == 0) check("resp0 unexpected", rd0, 32'hxxxxxxxx);
      else check("resp0 readdataM", rd0, q0.pop_front());
    end
    prevStall0 = stall0;
    prevRst0   = rst;
  end

  // Issue one aligned access and hold it until RESP; counts stalled cycles.
  task automatic doAccess(input bit zw, input bit wr, input logic [1:0] sz, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] expRd);
    int  stallCycles;
    bit  done;
    @(posedge clk); #1;
    memwriteM  = wr;
    sizeM      = sz;
    unsignedM  = uns;
    aluoutM    = addr;
    writedataM = wd;
    if (zw) begin memen0 = 1'b1; q0.push_back(expRd); end
    else    begin memen2 = 1'b1; q2.push_back(expRd); end
    stallCycles = 0;
    done = 1'b0;
    #1;
    if (stallOf(zw)) stallCycles++;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk); #1;
      if (!stallOf(zw)) done = 1'b1;
      else stallCycles++;
    end
    memen0 = 1'b0;
    memen2 = 1'b0;
    if (!done) begin
      nChecks++;
      nFails++;
      $display("FAIL access timeout: addr %h still stalled, expected RESP within 40 cycles", addr);
    end
    check($sformatf("stall cycles @%h", addr), 32'(stallCycles), zw ? 32'd1 : 32'd3);
  endtask

  // Misaligned request on the two-wait-state instance.
  task automatic doMisaligned(input bit wr, input logic [1:0] sz, input logic [31:0] addr,
                              input logic [31:0] expRd);
    @(posedge clk); #1;
    memwriteM  = wr;
    sizeM      = sz;
    unsignedM  = 1'b0;
    aluoutM    = addr;
    writedataM = 32'hCAFEF00D;
    memen2     = 1'b1;
    #1;
    check($sformatf("adelM misaligned @%h", addr), 32'(adel2), 32'(!wr));
    check($sformatf("adesM misaligned @%h", addr), 32'(ades2), 32'(wr));
    check($sformatf("stallM misaligned @%h", addr), 32'(stall2), 32'd0);
    @(posedge clk); #1;
    check($sformatf("not accepted @%h", addr), 32'(stall2), 32'd0);
    memen2 = 1'b0;
    #1;
    check("adelM pulse ended", 32'(adel2), 32'd0);
    check("adesM pulse ended", 32'(ades2), 32'd0);
    check("readdataM held", rd2, expRd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    memen2 = 1'b0; memen0 = 1'b0;
    memwriteM = 1'b0; sizeM = SZ_WORD; unsignedM = 1'b0;
    aluoutM = 32'h0; writedataM = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset readdataM", rd2, 32'h0);
    check("reset stallM", 32'(stall2), 32'd0);
    check("reset adelM", 32'(adel2), 32'd0);
    check("reset adesM", 32'(ades2), 32'd0);
    check("reset readdataM (0 wait)", rd0, 32'h0);
    rst = 1'b0;

    // zw, wr, size, uns, addr, wdata, expected readdataM at RESP
    doAccess(0, 1, SZ_WORD, 0, 32'h10, 32'hDEADBEEF, 32'h00000000);
    doAccess(0, 0, SZ_WORD, 0, 32'h10, 32'h0,        32'hDEADBEEF);
    doAccess(0, 0, SZ_BYTE, 0, 32'h13, 32'h0,        32'hFFFFFFDE);
    doAccess(0, 0, SZ_BYTE, 1, 32'h13, 32'h0,        32'h000000DE);
    doAccess(0, 0, SZ_HALF, 0, 32'h10, 32'h0,        32'hFFFFBEEF);
    doAccess(0, 0, SZ_HALF, 1, 32'h12, 32'h0,        32'h0000DEAD);
    doAccess(0, 1, SZ_BYTE, 0, 32'h11, 32'hAABBCC55, 32'h0000DEAD);
    doAccess(0, 0, SZ_WORD, 0, 32'h10, 32'h0,        32'hDEAD55EF);
    doAccess(0, 0, SZ_BYTE, 0, 32'h11, 32'h0,        32'h00000055);

    doMisaligned(0, SZ_WORD, 32'h12, 32'h00000055);
    doMisaligned(1, SZ_HALF, 32'h11, 32'h00000055);
    doAccess(0, 0, SZ_WORD, 0, 32'h10, 32'h0,        32'hDEAD55EF);

    // Store aborted by reset while in WAIT.
    @(posedge clk); #1;
    memwriteM = 1'b1; sizeM = SZ_WORD; aluoutM = 32'h10; writedataM = 32'h12345678;
    memen2 = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    memen2 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("stallM after mid-WAIT reset", 32'(stall2), 32'd0);
    check("readdataM after mid-WAIT reset", rd2, 32'h0);
    doAccess(0, 0, SZ_WORD, 0, 32'h10, 32'h0,        32'hDEAD55EF);

    doAccess(0, 1, SZ_HALF, 0, 32'h12, 32'h12348001, 32'hDEAD55EF);
    doAccess(0, 0, SZ_HALF, 0, 32'h12, 32'h0,        32'hFFFF8001);
    doAccess(0, 0, SZ_HALF, 1, 32'h10, 32'h0,        32'h000055EF);
    doAccess(0, 0, SZ_WORD, 0, 32'h10, 32'h0,        32'h800155EF);
    doAccess(0, 0, 2'b11,   0, 32'h10, 32'h0,        32'h800155EF);

    // Zero wait states plus address aliasing.
    doAccess(1, 1, SZ_WORD, 0, 32'h1000, 32'hA5A5A5A5, 32'h00000000);
    doAccess(1, 0, SZ_WORD, 0, 32'h0,    32'h0,        32'hA5A5A5A5);

    repeat (4) @(posedge clk);
    #1;
    check("pending responses (2 wait)", 32'(q2.size()), 32'd0);
    check("pending responses (0 wait)", 32'(q0.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, number of 32-bit words stored; power of two.
REQ-002 Parameter WAIT_CYCLES, default 2, extra wait states per access (0..15).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 memenM  in  1  memory-stage access request (load or store).
REQ-006 memwriteM  in  1  1 = store, 0 = load; valid with memenM.
REQ-007 sizeM  in  2  00 byte, 01 halfword, 10 word, 11 treated as word.
REQ-008 unsignedM  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
REQ-009 aluoutM  in  32  byte address.
REQ-010 writedataM  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
REQ-011 readdataM  out  32  load result, extended to 32 bits.
REQ-012 stallM  out  1  1 = access in progress; CPU holds F/D/E/M stages and keeps request inputs stable.
REQ-013 adelM  out  1  one-cycle pulse: misaligned load.
REQ-014 adesM  out  1  one-cycle pulse: misaligned store.

Function
REQ-015 States IDLE, WAIT, RESP; a wait counter counts WAIT_CYCLES down to 0.
REQ-016 IDLE: memenM=1 with aligned address is accepted; address, data, size, write and unsigned are latched at the edge; next state WAIT if WAIT_CYCLES>0, otherwise RESP.
REQ-017 stallM is combinationally 1 in IDLE during an accepted request, 1 throughout WAIT, and 0 in RESP and in idle IDLE.
REQ-018 WAIT: the counter decrements each cycle; when it reaches 0, next state is RESP.
REQ-019 RESP lasts exactly one cycle, then IDLE; requests are not accepted in RESP.
REQ-020 Load latency: readdataM is valid in the RESP cycle, which is WAIT_CYCLES+1 cycles after the accept cycle.
REQ-021 Store commit: the RAM is written at the edge entering RESP; readdataM is unchanged by stores.
REQ-022 Byte lanes are little-endian: byte uses lane aluoutM[1:0]; halfword uses lanes {aluoutM[1],0}+1..0; word uses all four lanes.
REQ-023 Load extract: the selected byte/half is shifted to bit 0 and extended per unsignedM; word loads pass through.
REQ-024 Alignment: half with addr[0]=1, or word with addr[1:0]!=0, is misaligned.
REQ-025 Misaligned request in IDLE: not accepted, stallM stays 0, RAM unchanged, readdataM unchanged; adelM (load) or adesM (store) is 1 for that cycle only.
REQ-026 Word index = aluoutM[log2(DEPTH_WORDS)+1:2]; upper address bits are ignored (aliasing wrap).
REQ-027 readdataM holds the last load result until the next load reaches RESP.
REQ-028 Back-to-back: a request present in the cycle after RESP (IDLE) is accepted normally; zero idle-cycle gap.

Reset
REQ-029 rst=1 forces state IDLE, counter 0, readdataM 0, stallM 0, adelM 0, adesM 0 at the next edge.
REQ-030 Reset during WAIT discards the pending access; a pending store is not committed.
REQ-031 RAM contents are not cleared by reset.

Structure
REQ-032 Shared package dmem_pkg holds the sizeM encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the state encoding.
REQ-033 Lane write-enable generation, write-data replication and load extraction go in combinational sub-module mem_align; RAM and FSM stay in dmem_responder.

Verification
REQ-034 WAIT_CYCLES=2: sw 0xDEADBEEF @0x10, then lw @0x10 -> stallM high 3 cycles per access; readdataM=0xDEADBEEF in the RESP cycle.
REQ-035 After REQ-034: lb @0x13 -> 0xFFFFFFDE; lbu @0x13 -> 0x000000DE; lh @0x10 -> 0xFFFFBEEF; lhu @0x12 -> 0x0000DEAD.
REQ-036 sb 0x55 @0x11, then lw @0x10 -> 0xDEAD55EF (other lanes untouched).
REQ-037 lw @0x12 -> adelM pulses 1 cycle, stallM=0, readdataM unchanged; sh @0x11 -> adesM pulses, RAM unchanged.
REQ-038 sw 0x12345678 @0x10 with rst asserted mid-WAIT -> lw @0x10 after reset returns the prior value 0xDEAD55EF; stallM=0 after reset.
REQ-039 WAIT_CYCLES=0, DEPTH_WORDS=1024: sw 0xA5A5A5A5 @0x1000, then lw @0x0 -> 1-cycle stall each; readdataM=0xA5A5A5A5 (address alias wrap).
